data_sram_bridge: RTL and testbench
===================================

// Module: data_sram_bridge
// PURPOSE
//  MEM-stage bridge between the load/store translator and an SRAM-like data bus.
//  Turns the translator's single-cycle request into a two-phase bus transaction:
//  an address/request phase closed by addr_ok, then a data phase closed by data_ok.
//  It stalls the pipeline while a transaction is outstanding and holds the read word
//  until the pipeline advances. It feeds ReadData back to the translator.
// PARAMETERS
//  KSEG_MAP  1  1: map addresses 0x8000_0000-0xBFFF_FFFF to physical by clearing bits [31:29]; 0: pass through
// PORTS
//  clk           in   1   clock, all state on rising edge
//  resetn        in   1   asynchronous active-low reset
//  mem_en        in   1   access request from translator (already 0 on Adel/Ades)
//  mem_wen       in   4   byte write enables; 0 = load
//  mem_addr      in   32  word-aligned address
//  mem_wdata     in   32  lane-replicated store data
//  mem_advance   in   1   pipeline moves MEM->WB this cycle (no other stall)
//  flush         in   1   exception/flush of the MEM-stage instruction
//  mem_rdata     out  32  read word returned to translator
//  mem_stall     out  1   hold pipeline
//  data_req      out  1   bus request
//  data_wr       out  1   1 = write
//  data_size     out  2   0 byte, 1 half, 2 word
//  data_addr     out  32  bus address (physical)
//  data_wdata    out  32  bus write data
//  data_addr_ok  in   1   request accepted
//  data_data_ok  in   1   read data valid / write complete
//  data_rdata    in   32  bus read data
// BEHAVIOUR
//  Reset: state IDLE, discard 0, latched req regs 0, mem_rdata 0, data_req 0, mem_stall 0.
//  FSM states: IDLE, ADDR, DATA, DONE.
//   IDLE: if mem_en & !flush: data_req=1 from live inputs; fields latched every IDLE cycle;
//         addr_ok -> DATA, else -> ADDR. If flush or !mem_en: no request, stay in IDLE.
//   ADDR: data_req=1 with latched fields, stable until addr_ok; addr_ok -> DATA.
//   DATA: data_req=0; on data_ok capture data_rdata into mem_rdata (loads only), then
//         -> DONE if !discard, -> IDLE if discard (clear discard).
//   DONE: mem_stall=0; mem_rdata held; mem_advance or flush -> IDLE.
//  mem_stall = (IDLE & mem_en & !flush) | ADDR | DATA.
//  Best case: 2 stall cycles (addr_ok in the IDLE cycle, data_ok in the first DATA
//   cycle); result visible in DONE on the 3rd cycle.
//  data_wr = |mem_wen. data_size: 1111->2; 0011/1100->1; one-hot->0; load -> 2
//   (full word; the translator extracts the lane). Other wen patterns: size 2.
//  data_addr = mem_addr, with [31:29] cleared when KSEG_MAP=1 and addr[31:30]=2'b10.
//  Flush: never withdraws an issued request (bus rule).
//   - In ADDR: keep req until addr_ok, set discard.
//   - In DATA: set discard.
//   - Discarded data is not written to mem_rdata.
//   - mem_stall stays high until the discarded transaction drains, preserving bus order.
//  data_ok in ADDR is a protocol violation: ignored; the FSM does not leave ADDR on it.
//  Asynchronous reset mid-transaction: FSM to IDLE immediately; bus agent also reset.
//  Back-to-back: DONE->IDLE on mem_advance, and the next instruction issues in the
//   following cycle.
// TESTING
//  1) Load at 0x0000_0010, addr_ok same cycle, data_ok next cycle, rdata=0xDEADBEEF
//     -> stall 2 cycles, data_size=2, data_wr=0, mem_rdata=0xDEADBEEF in DONE.
//  2) Store byte wen=0100 at 0xA000_0022 -> data_wr=1, size=0, data_addr=0x0000_0020,
//     wdata passed through unchanged.
//  3) addr_ok delayed 3 cycles -> data_req and data_addr stable all 4 cycles; stall
//     held until the cycle after data_ok.
//  4) Flush asserted in DATA -> data_ok drains, mem_rdata unchanged, FSM returns to
//     IDLE, not DONE.
//  5) DONE with mem_advance=0 for 2 cycles -> mem_stall=0 and mem_rdata held; then
//     mem_advance=1 with a new mem_en -> new request next cycle.
//  6) resetn low while in ADDR -> data_req=0, mem_stall=0, mem_rdata=0 that cycle.

Source files
------------

// File: rtl/data_sram_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the data memory
// agent (slave): a request phase closed by data_addr_ok, then a data phase
// closed by data_data_ok.
interface data_sram_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// MEM-stage bridge from the load/store translator to the SRAM-like data bus.
// A single-cycle translator request becomes a request phase plus a data phase.
// The pipeline is stalled while a transaction is open. A flushed transaction is
// still completed on the bus, but its read data is dropped.
module data_sram_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_advance,
    input  logic        flush,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    data_sram_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte-enable pattern to bus transfer size; loads and odd patterns move a full word.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b1111:                            size = 2'd2;
            4'b0011, 4'b1100:                   size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Virtual to physical: kseg0/kseg1 fold onto low memory, the bus sees word addresses.
    function automatic logic [31:0] to_phys(input logic [31:0] vaddr);
        logic [31:0] paddr;
        if ((KSEG_MAP == 1'b1) && (vaddr[31:30] == 2'b10)) begin
            paddr = {3'b000, vaddr[28:2], 2'b00};
        end else begin
            paddr = {vaddr[31:2], 2'b00};
        end
        return paddr;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        discard_r;
    logic        discard_s;
    logic        wr_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;

    logic        live_wr_s;
    logic [1:0]  live_size_s;
    logic [31:0] live_addr_s;
    logic        req_s;
    logic        stall_s;
    logic        capture_s;
    logic        wr_s;
    logic [1:0]  size_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;

    assign live_wr_s   = |mem_wen;
    assign live_size_s = wen_to_size(mem_wen);
    assign live_addr_s = to_phys(mem_addr);

    // FSM state and the flag marking a flushed transaction still owned by the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            discard_r <= discard_s;
        end
    end

    // Request fields follow the live inputs while idle so ADDR replays exactly what was offered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (state_r == ST_IDLE) begin
            wr_r    <= live_wr_s;
            size_r  <= live_size_s;
            addr_r  <= live_addr_s;
            wdata_r <= mem_wdata;
        end
    end

    // Read word register: only a load that completes without being discarded updates it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r <= 32'd0;
        end else if (capture_s) begin
            rdata_r <= bus.data_rdata;
        end
    end

    // Next state, discard bookkeeping and bus drive for the current phase.
    always_comb begin
        state_s   = state_r;
        discard_s = discard_r;
        req_s     = 1'b0;
        stall_s   = 1'b0;
        capture_s = 1'b0;
        wr_s      = wr_r;
        size_s    = size_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        case (state_r)
            ST_IDLE: begin
                wr_s      = live_wr_s;
                size_s    = live_size_s;
                addr_s    = live_addr_s;
                wdata_s   = mem_wdata;
                discard_s = 1'b0;
                if (mem_en && !flush) begin
                    req_s   = 1'b1;
                    stall_s = 1'b1;
                    if (bus.data_addr_ok) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // An issued request is never withdrawn; a flush only marks it for discard.
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (flush) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
                if (bus.data_addr_ok) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                stall_s = 1'b1;
                if (bus.data_data_ok) begin
                    discard_s = 1'b0;
                    if (discard_r || flush) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_DONE;
                        capture_s = ~wr_r;
                    end
                end else if (flush) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
            end
            ST_DONE: begin
                if (mem_advance || flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                discard_s = 1'b0;
            end
        endcase
    end

    // Request and stall are qualified by reset so they drop in the same cycle reset asserts.
    assign bus.data_req   = req_s & resetn;
    assign bus.data_wr    = wr_s;
    assign bus.data_size  = size_s;
    assign bus.data_addr  = addr_s;
    assign bus.data_wdata = wdata_s;
    assign mem_stall      = stall_s & resetn;
    assign mem_rdata      = rdata_r;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: a bus-slave agent with configurable or random
// latencies, an instruction-level reference model feeding two scoreboard queues
// (bus requests and the read word at stall release), and a monitor that
// compares both against the DUT.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_advance;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    data_sram_bridge_if bus ();

    data_sram_bridge #(.KSEG_MAP(1'b1)) dut (
        .clk(clk), .resetn(resetn), .mem_en(mem_en), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_advance(mem_advance),
        .flush(flush), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event, expected one", name);
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic logic [31:0] rdata_of(input logic [31:0] p);
        return p * 32'h9E37_79B9 + 32'h1357_9BDF;
    endfunction

    function automatic logic [1:0] exp_size(input logic [3:0] w);
        if ($countones(w) == 1) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] exp_phys(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFC;
        return a & 32'hFFFF_FFFC;
    endfunction

    logic [66:0] bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd = 32'd0;

    // ---------------- bus slave agent ----------------
    logic        pend;
    logic [31:0] pend_addr;
    int          req_age, dat_age, rnd_aok, rnd_dok;
    int          cfg_aok = 0;
    int          cfg_dok = 0;
    int          aok_now, dok_now;
    bit          rand_lat = 1'b0;
    bit          use_dir = 1'b1;
    bit          rand_spur = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] dir_rdata = 32'd0;

    assign aok_now          = rand_lat ? rnd_aok : cfg_aok;
    assign dok_now          = rand_lat ? rnd_dok : cfg_dok;
    assign bus.data_addr_ok = bus.data_req && (req_age >= aok_now);
    assign bus.data_data_ok = pend ? (dat_age >= dok_now) : spur;
    assign bus.data_rdata   = pend ? (use_dir ? dir_rdata : rdata_of(pend_addr)) : 32'hBAD0_BAD0;

    // Agent phase tracking; reset together with the DUT.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend      <= 1'b0;
            pend_addr <= 32'd0;
            req_age   <= 0;
            dat_age   <= 0;
            rnd_aok   <= 0;
            rnd_dok   <= 0;
        end else begin
            if (bus.data_req && bus.data_addr_ok) begin
                pend      <= 1'b1;
                pend_addr <= bus.data_addr;
                req_age   <= 0;
                dat_age   <= 0;
                rnd_aok   <= int'($urandom_range(0, 3));
            end else if (bus.data_req) begin
                req_age <= req_age + 1;
            end
            if (pend && bus.data_data_ok) begin
                pend    <= 1'b0;
                rnd_dok <= int'($urandom_range(0, 3));
            end else if (pend) begin
                dat_age <= dat_age + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_stall, prev_pend;
    logic [66:0] prev_fields;
    logic        acc_wr;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;

    // Compares accepted requests, request stability and the read word at stall release.
    always @(negedge clk) begin : mon
        logic [66:0] cur;
        logic [66:0] eb;
        logic [31:0] er;
        cur = {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata};
        if (!resetn) begin
            prev_stall <= 1'b0;
            prev_pend  <= 1'b0;
        end else begin
            if (prev_stall && !mem_stall) begin
                if (rd_q.size() == 0) begin
                    fail_now("rdata_q_empty");
                end else begin
                    er = rd_q.pop_front();
                    chk("rdata_at_release", 72'(mem_rdata), 72'(er));
                end
            end
            if (prev_pend) begin
                chk("req_held", 72'(bus.data_req), 72'(1'b1));
                chk("fields_stable", 72'(cur), 72'(prev_fields));
            end
            if (bus.data_req && bus.data_addr_ok) begin
                if (bus_q.size() == 0) begin
                    fail_now("bus_q_empty");
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_request", 72'(cur), 72'(eb));
                end
                acc_wr    <= bus.data_wr;
                acc_size  <= bus.data_size;
                acc_addr  <= bus.data_addr;
                acc_wdata <= bus.data_wdata;
            end
            prev_stall  <= mem_stall;
            prev_pend   <= bus.data_req && !bus.data_addr_ok;
            prev_fields <= cur;
        end
    end

    // ---------------- driver ----------------
    // mode: 0 normal, 1 flushed before issue, 2 flushed after issue.
    task automatic do_instr(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input int mode, input int hold,
                            output int n);
        logic [31:0] phys;
        n = 0;
        @(posedge clk);
        #1;
        mem_en      = 1'b1;
        mem_wen     = wen;
        mem_addr    = addr;
        mem_wdata   = wdata;
        mem_advance = 1'b0;
        flush       = (mode == 1);
        spur        = rand_spur && ($urandom_range(0, 7) == 0);
        if (mode == 1) begin
            @(negedge clk);
            chk("preflush_req", 72'(bus.data_req), 72'(1'b0));
            chk("preflush_stall", 72'(mem_stall), 72'(1'b0));
            flush  = 1'b0;
            mem_en = 1'b0;
            return;
        end
        phys = exp_phys(addr);
        bus_q.push_back({|wen, exp_size(wen), phys, wdata});
        if (mode == 0 && wen == 4'b0000) last_rd = use_dir ? dir_rdata : rdata_of(phys);
        rd_q.push_back(last_rd);
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n > 60) begin
                fail_now("stall_timeout");
                break;
            end
            @(posedge clk);
            #1;
            flush = (mode == 2 && n == 1);
            if (flush) mem_en = 1'b0;
            spur = rand_spur && ($urandom_range(0, 7) == 0);
        end
        flush = 1'b0;
        spur  = 1'b0;
        if (mode == 0) begin
            for (int h = 0; h < hold; h++) begin
                mem_advance = 1'b0;
                @(negedge clk);
                chk("done_hold_stall", 72'(mem_stall), 72'(1'b0));
                chk("done_hold_rdata", 72'(mem_rdata), 72'(last_rd));
            end
        end
        mem_advance = 1'b1;
    endtask

    logic [3:0] wen_tab [0:10] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101};

    initial begin
        int          n;
        int          mode;
        logic [1:0]  top;
        logic [31:0] r;

        resetn = 1'b0; mem_en = 1'b1; mem_wen = 4'd0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_advance = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_stall", 72'(mem_stall), 72'(1'b0));
        chk("reset_req", 72'(bus.data_req), 72'(1'b0));
        chk("reset_rdata", 72'(mem_rdata), 72'(32'd0));
        mem_en = 1'b0;
        #1 resetn = 1'b1;

        // Best-case load.
        cfg_aok = 0; cfg_dok = 0; dir_rdata = 32'hDEAD_BEEF;
        do_instr(4'b0000, 32'h0000_0010, 32'd0, 0, 0, n);
        chk("t1_stall_cycles", 72'(n), 72'(2));
        chk("t1_rdata", 72'(mem_rdata), 72'(32'hDEAD_BEEF));
        chk("t1_size", 72'(acc_size), 72'(2'd2));
        chk("t1_wr", 72'(acc_wr), 72'(1'b0));

        // Byte store through kseg1.
        do_instr(4'b0100, 32'hA000_0022, 32'h5555_5555, 0, 0, n);
        chk("t2_wr", 72'(acc_wr), 72'(1'b1));
        chk("t2_size", 72'(acc_size), 72'(2'd0));
        chk("t2_addr", 72'(acc_addr), 72'(32'h0000_0020));
        chk("t2_wdata", 72'(acc_wdata), 72'(32'h5555_5555));
        chk("t2_rdata_kept", 72'(mem_rdata), 72'(32'hDEAD_BEEF));

        // addr_ok held back three cycles.
        cfg_aok = 3; dir_rdata = 32'h1234_5678;
        do_instr(4'b0000, 32'h0000_0400, 32'd0, 0, 0, n);
        chk("t3_stall_cycles", 72'(n), 72'(5));
        chk("t3_rdata", 72'(mem_rdata), 72'(32'h1234_5678));

        // Flush while in the data phase.
        cfg_aok = 0; cfg_dok = 1; dir_rdata = 32'hFFFF_0000;
        do_instr(4'b0000, 32'h0000_0800, 32'd0, 2, 0, n);
        chk("t4_stall_cycles", 72'(n), 72'(3));
        chk("t4_rdata_unchanged", 72'(mem_rdata), 72'(32'h1234_5678));

        // DONE held, then back-to-back issue.
        cfg_dok = 0; dir_rdata = 32'h0BAD_F00D;
        do_instr(4'b0000, 32'h8000_0040, 32'd0, 0, 2, n);
        chk("t5_stall_cycles", 72'(n), 72'(2));
        dir_rdata = 32'h7777_1111;
        do_instr(4'b0000, 32'h0000_0044, 32'd0, 0, 0, n);
        chk("t5_next_issue", 72'(n), 72'(2));
        chk("t5_rdata", 72'(mem_rdata), 72'(32'h7777_1111));

        // Randomized traffic against the model.
        use_dir = 1'b0; rand_lat = 1'b1; rand_spur = 1'b1;
        for (int i = 0; i < 300; i++) begin
            top  = 2'($urandom_range(0, 3));
            r    = $urandom();
            mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
            do_instr(wen_tab[$urandom_range(0, 10)], {top, r[29:0]}, $urandom(), mode,
                     int'($urandom_range(0, 2)), n);
        end
        // Final read of a known word so mem_rdata is non-zero before reset.
        use_dir = 1'b1; rand_lat = 1'b0; rand_spur = 1'b0; cfg_aok = 0; cfg_dok = 0;
        dir_rdata = 32'hA5A5_5A5A;
        do_instr(4'b0000, 32'h0000_0200, 32'd0, 0, 0, n);

        // Asynchronous reset while in ADDR.
        cfg_aok = 10;
        @(posedge clk);
        #1;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0100; mem_advance = 1'b0;
        bus_q.push_back({1'b0, 2'd2, 32'h0000_0100, mem_wdata});
        @(negedge clk);
        chk("t6_req_issued", 72'(bus.data_req), 72'(1'b1));
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t6_req_in_addr", 72'(bus.data_req), 72'(1'b1));
        chk("t6_rdata_before", 72'(mem_rdata), 72'(32'hA5A5_5A5A));
        resetn = 1'b0;
        #1;
        chk("t6_req", 72'(bus.data_req), 72'(1'b0));
        chk("t6_stall", 72'(mem_stall), 72'(1'b0));
        chk("t6_rdata", 72'(mem_rdata), 72'(32'd0));
        mem_en = 1'b0;
        bus_q.delete();
        rd_q.delete();
        last_rd = 32'd0;
        @(negedge clk);
        #1 resetn = 1'b1;

        // Recovery after reset.
        cfg_aok = 0; dir_rdata = 32'hCAFE_0001;
        do_instr(4'b0000, 32'h0000_0300, 32'd0, 0, 0, n);
        chk("t6_recover_stall", 72'(n), 72'(2));
        chk("t6_recover_rdata", 72'(mem_rdata), 72'(32'hCAFE_0001));

        @(posedge clk);
        #1 mem_en = 1'b0; mem_advance = 1'b0;
        repeat (3) @(negedge clk);
        if (bus_q.size() != 0) fail_now("bus_q_leftover");
        if (rd_q.size() != 0) fail_now("rd_q_leftover");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
